// File: rtl/ad7682_seq_ctrl.sv
// ad7682_seq_ctrl: AD7682 conversion sequencer and serial reader with a 2-frame CFG tag pipe.
// Define ADC_AVG4_EN to average 4 consecutive results per channel before strobing.
module ad7682_seq_ctrl #(
  parameter int         CLK_DIV      = 2,
  parameter int         CONV_CYCLES  = 180,
  parameter int         QUIET_CYCLES = 4,
  parameter logic [2:0] REF_SEL      = 3'b001
) (
  input  logic        clk75Mhz,
  input  logic        reset,
  input  logic        run,
  input  logic [1:0]  chan_last,
  input  logic        adc_sdo,
  output logic        adc_sdi,
  output logic        adc_clk,
  output logic        adc_cvst,
  output logic [15:0] result,
  output logic [1:0]  result_chan,
  output logic        result_valid,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, CONVERT, READ, DONE, QUIET} state_t;
  state_t state, state_n;
  logic [15:0] cnt;
  logic [3:0]  div_cnt;
  logic [5:0]  half;
  logic [15:0] sdi_sr, sdo_sr, res_n;
  logic [13:0] cfg;
  logic [1:0]  ptr, ptr_n, tag_d1, tag_d2, disc;
  logic        tick, rise, fall, conv_end, quiet_end, read_end, eligible, strobe, advance;
  assign cfg       = {1'b1, 3'b111, 1'b0, ptr, 1'b1, REF_SEL, 2'b00, 1'b1};
  assign conv_end  = cnt == 16'(CONV_CYCLES - 1);
  assign quiet_end = cnt == 16'(QUIET_CYCLES - 1);
  // READ spans 33 SCLK half-periods: odd halves are high, half 32 is the trailing low
  assign tick      = state == READ && div_cnt == 4'(CLK_DIV - 1);
  assign rise      = tick && !half[0] && !half[5];
  assign fall      = tick && half[0];
  assign read_end  = tick && half[5];
  assign eligible  = state == DONE && disc == 2'd0;
  assign ptr_n     = ptr >= chan_last ? 2'd0 : ptr + 2'd1;
  assign adc_sdi   = sdi_sr[15];
`ifdef ADC_AVG4_EN
  logic [17:0] acc, sum;
  logic [1:0]  acnt;
  assign sum     = acc + {2'b00, sdo_sr};
  assign strobe  = eligible && acnt == 2'd3;
  assign advance = strobe;
  assign res_n   = sum[17:2];
  always_ff @(posedge clk75Mhz or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      acnt <= '0;
    end else if (state == IDLE) begin
      acc  <= '0;
      acnt <= '0;
    end else if (eligible) begin
      acc  <= strobe ? '0 : sum;
      acnt <= acnt + 2'd1;
    end
  end
`else
  assign strobe  = eligible;
  assign advance = state == DONE;
  assign res_n   = sdo_sr;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = run ? CONVERT : IDLE;
      CONVERT: state_n = conv_end ? READ : CONVERT;
      READ:    state_n = read_end ? DONE : READ;
      DONE:    state_n = QUIET;
      QUIET:   state_n = quiet_end ? (run ? CONVERT : IDLE) : QUIET;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk75Mhz or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      div_cnt      <= '0;
      half         <= '0;
      sdi_sr       <= '0;
      sdo_sr       <= '0;
      ptr          <= '0;
      tag_d1       <= '0;
      tag_d2       <= '0;
      disc         <= 2'd2;
      adc_clk      <= 1'b0;
      adc_cvst     <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_chan  <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= state_n != state ? '0 : cnt + 16'd1;
      div_cnt      <= state != READ || tick ? '0 : div_cnt + 4'd1;
      half         <= state != READ ? '0 : half + 6'(tick);
      adc_clk      <= rise ? 1'b1 : fall ? 1'b0 : adc_clk;
      adc_cvst     <= state_n == CONVERT;
      busy         <= state_n != IDLE;
      sdi_sr       <= state == CONVERT && conv_end ? {cfg, 2'b00} : fall ? {sdi_sr[14:0], 1'b0} : sdi_sr;
      sdo_sr       <= rise ? {sdo_sr[14:0], adc_sdo} : sdo_sr;
      result_valid <= strobe;
      if (state == IDLE && run)
        disc <= 2'd2;
      // the ADC applies a CFG two frames after it is written
      if (state == DONE) begin
        tag_d1 <= ptr;
        tag_d2 <= tag_d1;
        if (disc != 2'd0)
          disc <= disc - 2'd1;
      end
      if (advance)
        ptr <= ptr_n;
      if (strobe) begin
        result      <= res_n;
        result_chan <= tag_d2;
      end
    end
  end
endmodule

// File: tb/tb_ad7682_seq_ctrl.sv
// tb_ad7682_seq_ctrl: scoreboard bench for ad7682_seq_ctrl driven by a behavioural AD7682 model.
`timescale 1ns/1ps
module tb_ad7682_seq_ctrl;
  logic        clk75Mhz = 1'b0, reset = 1'b0, run = 1'b0, adc_sdo = 1'b0;
  logic [1:0]  chan_last = 2'd3;
  logic        adc_sdi, adc_clk, adc_cvst, result_valid, busy;
  logic [15:0] result;
  logic [1:0]  result_chan;
  typedef struct packed {logic [15:0] val; logic [1:0] chan; logic [7:0] frame;} exp_t;
  exp_t        sbq[$];
  exp_t        sb_e;
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, frame_cnt = 0, rises = 0, cnv_len = 0, last_rise = 0;
  int          strobe_cyc = 0, prev_strobe_cyc = 0, prev_strobe_frame = -10;
  logic        prev_cvst = 1'b0, prev_clk = 1'b0, prev_busy = 1'b0, prev_valid = 1'b0;
  logic [13:0] cfg_sh = '0;
  logic [13:0] cfg_log [64];
  logic [15:0] sdo_sh = '0;
  logic [13:0] cfg_ch2 = 14'b1_111_010_1_001_00_1;

  ad7682_seq_ctrl dut (
    .clk75Mhz(clk75Mhz), .reset(reset), .run(run), .chan_last(chan_last),
    .adc_sdo(adc_sdo), .adc_sdi(adc_sdi), .adc_clk(adc_clk), .adc_cvst(adc_cvst),
    .result(result), .result_chan(result_chan), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk75Mhz = ~clk75Mhz;
  always @(posedge clk75Mhz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] cfg_word(input logic [1:0] ch);
    return {1'b1, 3'b111, 1'b0, ch, 1'b1, 3'b001, 2'b00, 1'b1};
  endfunction

  // conversion of frame n uses the CFG written in frame n-2
  function automatic logic [15:0] adc_word(input int n);
`ifdef ADC_AVG4_EN
    return n == 3 ? 16'd100 : n == 4 ? 16'd101 : n == 5 ? 16'd102 : n == 6 ? 16'd104 : 16'd0;
`else
    return n > 2 ? 16'h1230 + {14'd0, cfg_log[n-2][8:7]} : 16'hDEAD;
`endif
  endfunction

  // ADC model plus CNV/SCLK timing monitor
  always @(negedge clk75Mhz) begin
    if (!reset) begin
      frame_cnt = 0;
      rises     = 0;
      cnv_len   = 0;
      prev_cvst = 1'b0;
      prev_clk  = 1'b0;
      prev_busy = 1'b0;
      sdo_sh    = '0;
      adc_sdo   = 1'b0;
    end else begin
      if (adc_cvst && !prev_cvst) begin
        if (rises != 0) check("sclk_rises", 32'(rises), 32'd16);
        rises = 0;
        frame_cnt++;
      end
      if (adc_cvst) cnv_len++;
      if (!adc_cvst && prev_cvst) begin
        check("cnv_high", 32'(cnv_len), 32'd180);
        cnv_len = 0;
        sdo_sh  = adc_word(frame_cnt);
      end
      if (adc_clk && !prev_clk) begin
        if (rises != 0) check("sclk_period", 32'(cyc - last_rise), 32'd4);
        rises++;
        last_rise = cyc;
        cfg_sh = {cfg_sh[12:0], adc_sdi};
        if (rises == 14) cfg_log[frame_cnt] = cfg_sh;
      end
      if (!adc_clk && prev_clk) sdo_sh = {sdo_sh[14:0], 1'b0};
      if (!busy && prev_busy && rises != 0) begin
        check("sclk_rises", 32'(rises), 32'd16);
        rises = 0;
      end
      adc_sdo   = sdo_sh[15];
      prev_cvst = adc_cvst;
      prev_clk  = adc_clk;
      prev_busy = busy;
    end
  end

  // scoreboard: pops one expectation per result_valid
  always @(negedge clk75Mhz) begin
    if (!reset) begin
      prev_valid        = 1'b0;
      prev_strobe_frame = -10;
    end else begin
      if (result_valid) begin
        check("valid_gap", 32'(prev_valid), 32'd0);
        strobe_cyc = cyc;
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got result 0x%0h chan %0d, want no strobe", result, result_chan);
        end else begin
          sb_e = sbq.pop_front();
          check("result", 32'(result), 32'(sb_e.val));
          check("result_chan", 32'(result_chan), 32'(sb_e.chan));
          check("strobe_frame", 32'(frame_cnt), 32'(sb_e.frame));
          if (frame_cnt == prev_strobe_frame + 1)
            check("strobe_spacing", 32'(cyc - prev_strobe_cyc), 32'd251);
        end
        prev_strobe_frame = frame_cnt;
        prev_strobe_cyc   = cyc;
      end
      prev_valid = result_valid;
    end
  end

  task automatic wait_drain(input int max_cyc);
    int k = 0;
    while (sbq.size() != 0 && k < max_cyc) begin
      @(negedge clk75Mhz);
      k++;
    end
    check("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  task automatic wait_rise(input int fc, input int r);
    int k = 0;
    while (!(frame_cnt == fc && rises >= r) && k < 1000) begin
      @(negedge clk75Mhz);
      k++;
    end
    check("wait_sclk", 32'(frame_cnt == fc && rises >= r), 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy && k < max_cyc) begin
      @(negedge clk75Mhz);
      k++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk75Mhz);
    check("rst_cvst", 32'(adc_cvst), 32'd0);
    check("rst_sclk_sdi", 32'({adc_clk, adc_sdi}), 32'd0);
    check("rst_result", 32'({result, result_chan}), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef ADC_AVG4_EN
    chan_last = 2'd0;
    sbq.push_back(exp_t'{16'd101, 2'd0, 8'd6});
    #1 reset = 1'b1;
    run = 1'b1;
    wait_drain(2000);
    run = 1'b0;
    repeat (600) @(negedge clk75Mhz);
    check("avg_frames", 32'(frame_cnt), 32'd6);
    check("avg_idle_busy", 32'(busy), 32'd0);
`else
    for (int k = 0; k < 5; k++)
      sbq.push_back(exp_t'{16'h1230 + 16'(k % 4), 2'(k % 4), 8'(k + 3)});
    #1 reset = 1'b1;
    run = 1'b1;
    wait_drain(2500);
    for (int k = 0; k < 5; k++)
      check("cfg_word", 32'(cfg_log[k+1]), 32'(cfg_word(2'(k % 4))));
    check("cfg_ch2", 32'(cfg_log[3]), 32'(cfg_ch2));
    // stop mid-READ: frame 8 still completes and strobes channel 1
    sbq.push_back(exp_t'{16'h1231, 2'd1, 8'd8});
    wait_rise(8, 5);
    run = 1'b0;
    wait_drain(600);
    wait_idle(20);
    check("busy_fall", 32'(cyc - strobe_cyc), 32'd4);
    repeat (400) @(negedge clk75Mhz);
    check("stopped_frames", 32'(frame_cnt), 32'd8);
    check("stopped_cvst", 32'(adc_cvst), 32'd0);
    check("stopped_busy", 32'(busy), 32'd0);
    // async reset at SCLK rise 7, then the discard restarts
    run = 1'b1;
    wait_rise(9, 7);
    #2 reset = 1'b0;
    #1 check("arst_outputs", 32'({adc_cvst, adc_clk, adc_sdi, result_valid, busy, result, result_chan}), 32'd0);
    repeat (3) @(negedge clk75Mhz);
    sbq.push_back(exp_t'{16'h1230, 2'd0, 8'd3});
    sbq.push_back(exp_t'{16'h1231, 2'd1, 8'd4});
    #1 reset = 1'b1;
    wait_drain(1500);
    run = 1'b0;
    wait_idle(600);
    repeat (300) @(negedge clk75Mhz);
    check("final_frames", 32'(frame_cnt), 32'd4);
    check("final_busy", 32'(busy), 32'd0);
`endif
    check("leftover", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1);
  end
endmodule

// File: doc/ad7682_seq_ctrl.md
Name: ad7682_seq_ctrl

Overview:
- Conversion sequencer and serial reader for one AD7682 (4-channel, 16-bit) analog-input ADC.
- Drives CNV/SCLK/SDI and captures SDO.
- Steps through channels 0..chan_last and presents each result with its channel tag to the bus-register logic inside the FPGA2 bus block.
- Runs on the 75 MHz DCM clock produced at the FPGA2 top level.

Parameters:
- CLK_DIV, 2: SCLK half-period in clk75Mhz cycles (2 gives 18.75 MHz SCLK); legal range 1..15.
- CONV_CYCLES, 180: CNV-high time in clk75Mhz cycles (2.4 us, covers tCONV max 2.2 us).
- QUIET_CYCLES, 4: idle cycles after a frame, CNV low and SCLK low, before the next CNV rise.
- REF_SEL, 3'b001: REF field placed in the CFG word.

Ports:
- clk75Mhz  in  1  block clock, 75 MHz from DCM/BUFG
- reset  in  1  asynchronous reset, active low
- run  in  1  level; 1 = convert continuously, 0 = stop after current frame
- chan_last  in  2  highest channel in the scan (0..3)
- adc_sdo  in  1  ADC serial data out
- adc_sdi  out  1  ADC serial data in (CFG word)
- adc_clk  out  1  ADC SCLK
- adc_cvst  out  1  ADC CNV
- result  out  16  latest conversion result, unsigned
- result_chan  out  2  channel the result belongs to
- result_valid  out  1  one-cycle strobe; result and result_chan are new
- busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Interface (decided): one clock, clk75Mhz. reset is asynchronous, active-low.
- Reset values: adc_cvst=0, adc_clk=0, adc_sdi=0, result=0, result_chan=0, result_valid=0, busy=0. FSM=IDLE, channel pointer=0, discard counter=2.
- Reset asserted mid-frame: outputs go to their reset values immediately. No partial result is ever strobed.
- IDLE: leave when run=1. Load discard counter=2, go to CONVERT.
- CONVERT: adc_cvst=1 for exactly CONV_CYCLES cycles, then adc_cvst=0, go to READ.
- READ, 16 SCLK periods:
  - adc_clk toggles every CLK_DIV cycles, starting low.
  - adc_sdi updates on the falling SCLK edge (and before the first rise): CFG bits 13..0 MSB first, then 2 zeros.
  - adc_sdo is sampled on each rising SCLK edge, MSB first, into a 16-bit shift register.
  - adc_clk returns low after the 16th rise plus CLK_DIV cycles.
- DONE (1 cycle):
  - If discard counter=0: result <= shift register, result_chan <= tag, result_valid=1. Otherwise decrement the discard counter.
  - Advance the channel pointer: wraps to 0 after chan_last. If chan_last is lowered mid-scan below the pointer, the pointer wraps to 0.
- QUIET: QUIET_CYCLES cycles. Then CONVERT if run=1, else IDLE.
- Sampling run mid-frame: run is sampled only at the end of QUIET, so deassertion always completes the frame in progress.
- CFG word: [13]=1, [12:10]=3'b111 (unipolar, ref GND), [9:7]={1'b0, channel pointer}, [6]=1 (full BW), [5:3]=REF_SEL, [2:1]=2'b00 (no internal sequencer), [0]=1 (no readback).
- Pipeline tagging: the AD7682 applies the CFG two frames later. Keep a 2-deep tag pipe of the written channel; result_chan is the tag written two frames earlier. Because of this, the first 2 frames after leaving IDLE are never strobed.
- Frame period with defaults: 180 + 16·2·2 + 2 + 1 + 4 = 251 cycles (~3.35 us).
- result_valid is never asserted in consecutive cycles.

Optional Feature:
- Macro: ADC_AVG4_EN.
- Defined:
  - The channel pointer advances only every 4th strobe-eligible frame.
  - The 4 results are summed in an 18-bit accumulator; result = sum[17:2] (truncating).
  - result_valid pulses once per 4 frames.
  - The tag pipe and the 2-frame discard still apply. The discard completes before accumulation starts.
- Undefined: no accumulator; one strobe per frame as described above.

Test Plan:
- Reset release, run=1, chan_last=3, ADC model returns 16'h1230+channel:
  - First strobe occurs in the 3rd frame, with result=16'h1230, result_chan=0.
  - Subsequent strobes report channels 1, 2, 3, 0, with matching values.
- CFG check: capture adc_sdi over 14 rises for channel 2 with REF_SEL=3'b001 -> 14'b1_111_010_1_001_00_1.
- Timing: CNV high for exactly 180 cycles; 16 SCLK rises per frame; SCLK period 4 cycles; strobe spacing 251 cycles.
- run dropped mid-READ:
  - The frame completes, and its result is strobed if eligible.
  - adc_cvst stays 0 and busy falls 5 cycles after DONE.
- reset pulled low during READ at SCLK rise 7: all outputs are 0 asynchronously. After release with run=1, two frames are discarded again.
- ADC_AVG4_EN with chan_last=0 and samples 100, 101, 102, 104 -> a single strobe with result=101 (407>>2), result_chan=0.
